scpu_instr_dispatch: RTL
========================

Name: scpu_instr_dispatch

Overview:
- Buffers a 19-bit instruction stream from the host/pattern side.
- Issues instructions one at a time to the SCPU over its in_valid / instruction / busy / out_valid protocol.
- Sits directly upstream of the SCPU, replacing direct pattern drive of in_valid/instruction.
- Provides occupancy, issue/completion counters and a watchdog error for a hung CPU.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256.
- AW, 4, log2(DEPTH).
- TIMEOUT, 1024, max cycles allowed in WAIT before err is set; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- host_valid  in  1  host offers host_instr this cycle.
- host_instr  in  19  instruction word from host.
- host_ready  out  1  FIFO can accept; transfer occurs when host_valid && host_ready.
- flush  in  1  synchronous: discard all queued (not yet issued) entries.
- cpu_in_valid  out  1  one-cycle issue strobe to SCPU in_valid.
- cpu_instr  out  19  instruction to SCPU; valid while cpu_in_valid = 1.
- cpu_busy  in  1  SCPU busy.
- cpu_out_valid  in  1  SCPU completion pulse.
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- issued_cnt  out  16  instructions issued, wraps at 65535 -> 0.
- done_cnt  out  16  completions seen, wraps at 65535 -> 0.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (async, rst_n = 0), all registered:
  - host_ready = 0 while rst_n low; becomes 1 on the first clock edge after release.
  - cpu_in_valid = 0, cpu_instr = 0, level = 0, issued_cnt = 0, done_cnt = 0, err = 0.
  - FSM = IDLE; FIFO pointers = 0. Reset mid-operation discards the queue and any outstanding instruction.
- FIFO:
  - Circular buffer; rd/wr pointers are AW bits wide and wrap DEPTH-1 -> 0.
  - host_ready = (level < DEPTH) registered, so host_ready = 0 exactly when full.
  - Write while full is impossible by construction.
  - Simultaneous push and pop: level unchanged, both pointers advance.
- FSM states:
  - IDLE:
    - if level > 0 && !cpu_busy && !flush: pop the head into cpu_instr, assert cpu_in_valid for exactly 1 cycle, issued_cnt += 1, go to WAIT.
    - otherwise stay in IDLE.
  - WAIT:
    - cpu_in_valid = 0; watchdog counter increments every cycle.
    - on cpu_out_valid: done_cnt += 1, clear watchdog, go to IDLE.
    - on watchdog == TIMEOUT-1: set err, go to HALT.
  - HALT: no further issue; FIFO still accepts writes until full; leaves only via reset.
- Issue latency: from the head entry becoming present with cpu_busy = 0 in IDLE, cpu_in_valid rises on the next clock edge.
  - Minimum spacing is 2 cycles (issue, completion) plus the IDLE re-evaluation cycle.
- cpu_instr holds its last issued value between issues; it is never X after reset.
- cpu_out_valid in IDLE or HALT is ignored: no count change, err unaffected.
- flush:
  - Sets rd pointer = wr pointer and level = 0 in the same cycle.
  - A push in the same cycle as flush is also dropped.
  - An instruction already in WAIT is not affected; its completion is still counted.
  - flush in IDLE blocks issue that cycle.
- Only one instruction is ever outstanding: issued_cnt - done_cnt is in {0, 1} unless err is set.

Test Plan:
- Reset then push 3 words (0x00001, 0x12345, 0x7FFFF), cpu_busy = 0, SCPU model answers out_valid 4 cycles after in_valid:
  - three in_valid pulses in push order, each 1 cycle wide;
  - final issued_cnt = done_cnt = 3, level = 0.
- Fill with DEPTH = 16 entries while cpu_busy = 1:
  - host_ready drops after the 16th accept, level = 16;
  - release busy: entries drain in order, host_ready reasserts after the first pop.
- Push and issue in the same cycle at level = 5: level stays 5, data order preserved across pointer wrap (push 20 total).
- Queue 4 entries, issue 1, assert flush during WAIT:
  - level = 0;
  - the outstanding completion still gives done_cnt = 1;
  - no further in_valid.
- SCPU model never returns out_valid: err = 1 exactly TIMEOUT cycles after issue, FSM in HALT, no further cpu_in_valid despite level > 0.
- Assert rst_n low mid-WAIT with level = 3:
  - all outputs return to reset values immediately (asynchronously);
  - after release, no stale issue occurs.

Source files
------------

// File: rtl/scpu_instr_dispatch.sv
// rtl/scpu_instr_dispatch.sv - FIFO-buffered single-outstanding instruction issuer for the SCPU
//
// Purpose: queues 19-bit instructions from the host and hands them to the SCPU
// one at a time. The next instruction is only issued after the previous one has
// completed. A watchdog stops all issue if the SCPU never completes.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   host_valid/ready  host push handshake; host_instr is the pushed word
//   flush             drop every queued (not yet issued) entry
//   cpu_in_valid      one-cycle issue strobe; cpu_instr holds the issued word
//   cpu_busy          SCPU busy, blocks issue
//   cpu_out_valid     SCPU completion pulse
//   level             FIFO occupancy 0..DEPTH
//   issued_cnt        issue counter (wraps)
//   done_cnt          completion counter (wraps)
//   err               sticky watchdog error
module scpu_instr_dispatch #(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_valid,
    input  logic [18:0]   host_instr,
    output logic          host_ready,
    input  logic          flush,
    output logic          cpu_in_valid,
    output logic [18:0]   cpu_instr,
    input  logic          cpu_busy,
    input  logic          cpu_out_valid,
    output logic [AW:0]   level,
    output logic [15:0]   issued_cnt,
    output logic [15:0]   done_cnt,
    output logic          err
);

    localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [AW:0]    FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t         state;
    logic [18:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [WDW-1:0] wd_cnt;
    logic           push;
    logic           pop;
    logic [AW:0]    level_nxt;

    // host_ready is registered and only low when full, so it alone gates pushes.
    // A push coinciding with flush is dropped together with the queue.
    assign push = host_valid && host_ready && !flush;
    assign pop  = (state == IDLE) && (level != '0) && !cpu_busy && !flush;

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (!push && pop) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage carries no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_instr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            host_ready   <= 1'b0;
            cpu_in_valid <= 1'b0;
            cpu_instr    <= '0;
            issued_cnt   <= '0;
            done_cnt     <= '0;
            err          <= 1'b0;
            wd_cnt       <= '0;
        end else begin
            level      <= level_nxt;
            host_ready <= (level_nxt < FULL_LEVEL);

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // flush never coincides with a pop, and the push is suppressed,
            // so wr_ptr here is the pointer that stays valid.
            if (flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            cpu_in_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        cpu_instr    <= mem[rd_ptr];
                        cpu_in_valid <= 1'b1;
                        issued_cnt   <= issued_cnt + 1'b1;
                        wd_cnt       <= '0;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // A completion in the last watchdog cycle still wins.
                    if (cpu_out_valid) begin
                        done_cnt <= done_cnt + 1'b1;
                        wd_cnt   <= '0;
                        state    <= IDLE;
                    end else if (wd_cnt == WD_LAST) begin
                        err   <= 1'b1;
                        state <= HALT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
